// File: rtl/sort_pkg.sv
// Shared types and key helpers for the streaming byte sorter.
// Key is the byte with nibbles swapped: low nibble primary, high nibble secondary.
package sort_pkg;

   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

   localparam int SORT_N = 8;

   function automatic logic [7:0] sort_key(input logic [7:0] x);
      return {x[3:0], x[7:4]};
   endfunction

   function automatic logic key_gt(input logic [7:0] a, input logic [7:0] b);
      return sort_key(a) > sort_key(b);
   endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange; swaps only on strictly greater key, so equal keys keep order.
module sort_cmp_swap
   import sort_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] hi_o
);

   logic swap;

   assign swap = key_gt(lo, hi);
   assign lo_o = swap ? hi : lo;
   assign hi_o = swap ? lo : hi;

endmodule

// File: rtl/sort_stream_engine.sv
// Serial load of N bytes, N-cycle odd-even transposition sort, serial drain; first output N+1 cycles after final accept.
// Accepts input only in LOAD; holds out_data/out_last stable while out_ready is low in DRAIN.
module sort_stream_engine
   import sort_pkg::*;
#(
   parameter int N  = SORT_N,
   parameter int W  = 8,
   parameter int CW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        state;
   logic [CW-1:0] idx;
   logic [CW-1:0] phase;
   logic [CW-1:0] nxt_idx;
   logic [W-1:0]  mem      [N];
   logic [W-1:0]  even_buf [N];
   logic [W-1:0]  odd_buf  [N];
   logic [W-1:0]  next_buf [N];

   assign nxt_idx = idx + CW'(1);

   for (genvar i = 0; i < N/2; i++) begin : g_even
      sort_cmp_swap #(.W(W)) u_cs (
         .lo   (mem[2*i]),
         .hi   (mem[2*i+1]),
         .lo_o (even_buf[2*i]),
         .hi_o (even_buf[2*i+1])
      );
   end

   // Odd phases leave the two end entries untouched.
   assign odd_buf[0]   = mem[0];
   assign odd_buf[N-1] = mem[N-1];
   for (genvar i = 0; i < N/2 - 1; i++) begin : g_odd
      sort_cmp_swap #(.W(W)) u_cs (
         .lo   (mem[2*i+1]),
         .hi   (mem[2*i+2]),
         .lo_o (odd_buf[2*i+1]),
         .hi_o (odd_buf[2*i+2])
      );
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         next_buf[i] = phase[0] ? odd_buf[i] : even_buf[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= LOAD;
         idx       <= '0;
         phase     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         for (int i = 0; i < N; i++) mem[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  mem[idx] <= in_data;
                  if (idx == LAST) begin
                     idx      <= '0;
                     phase    <= '0;
                     state    <= SORT;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                  end else begin
                     idx <= nxt_idx;
                  end
               end
            end
            SORT: begin
               for (int i = 0; i < N; i++) mem[i] <= next_buf[i];
               phase <= phase + CW'(1);
               if (phase == LAST) begin
                  state     <= DRAIN;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  out_data  <= next_buf[0];
                  out_last  <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= LOAD;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_data  <= '0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                  end else begin
                     idx      <= nxt_idx;
                     out_data <= mem[nxt_idx];
                     out_last <= (nxt_idx == LAST);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_sort_stream_engine.sv
// Directed bench for sort_stream_engine with hand-computed sorted batches.
module tb_sort_stream_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   int cyc    = 0;
   int total  = 0;
   int passes = 0;
   int acc    = 0;

   logic [7:0] b_basic [8] = '{8'h17, 8'h25, 8'h03, 8'hF0, 8'h12, 8'h31, 8'h0A, 8'h52};
   logic [7:0] e_basic [8] = '{8'hF0, 8'h31, 8'h12, 8'h52, 8'h03, 8'h25, 8'h17, 8'h0A};
   logic [7:0] b_eq    [8] = '{8'h11, 8'h11, 8'h21, 8'h21, 8'h01, 8'h01, 8'h31, 8'h31};
   logic [7:0] e_eq    [8] = '{8'h01, 8'h01, 8'h11, 8'h11, 8'h21, 8'h21, 8'h31, 8'h31};
   logic [7:0] b_inc   [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
   logic [7:0] b_rev   [8] = '{8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00};
   logic [7:0] e_rev   [8] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70};
   logic [7:0] b_hi    [8] = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};

   sort_stream_engine #(.N(8), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passes++;
   endtask

   // Called at a negedge; returns at the negedge after the final accept.
   task automatic load_batch(input logic [7:0] d[8], input bit hold_aa);
      int to;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = d[i];
         to = 0;
         while (!in_ready && to < 100) begin
            @(negedge clk);
            to++;
         end
         if (!in_ready) check("load_timeout", 32'(i), 32'(8));
         acc = cyc;
         @(negedge clk);
      end
      in_valid = hold_aa;
      in_data  = hold_aa ? 8'hAA : 8'h00;
   endtask

   // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0 per valid cycle.
   task automatic drain_batch(input logic [7:0] e[8], input int mode, input bit chk_lat, input bit chk_rdy);
      int n = 0;
      int k = 0;
      int to = 0;
      bit seen = 0;
      while (n < 8 && to < 300) begin
         out_ready = (mode == 0) ? 1'b1 : (k % 3 == 0);
         if (out_valid) begin
            if (!seen) begin
               seen = 1;
               if (chk_lat) check("first_valid_latency", 32'(cyc - acc), 32'(9));
            end
            check("out_data", 32'(out_data), 32'(e[n]));
            if (out_ready) begin
               check("out_last", 32'(out_last), 32'(n == 7));
               n++;
            end
            k++;
         end
         if (chk_rdy) check("in_ready_low_busy", 32'(in_ready), 32'(0));
         if (n == 8) begin
            in_valid = 1'b0;
            in_data  = 8'h00;
         end
         @(negedge clk);
         to++;
      end
      if (n < 8) check("drain_timeout", 32'(n), 32'(8));
      out_ready = 1'b0;
      check("post_drain_valid", 32'(out_valid), 32'(0));
      check("post_drain_in_ready", 32'(in_ready), 32'(1));
      check("post_drain_busy", 32'(busy), 32'(0));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_last", 32'(out_last), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_out_data", 32'(out_data), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", 32'(in_ready), 32'(1));

      load_batch(b_basic, 1'b0);
      check("busy_in_sort", 32'(busy), 32'(1));
      check("in_ready_in_sort", 32'(in_ready), 32'(0));
      drain_batch(e_basic, 0, 1'b1, 1'b0);

      load_batch(b_basic, 1'b0);
      drain_batch(e_basic, 1, 1'b1, 1'b0);

      load_batch(b_eq, 1'b0);
      drain_batch(e_eq, 0, 1'b1, 1'b0);

      load_batch(b_basic, 1'b1);
      drain_batch(e_basic, 0, 1'b1, 1'b1);

      load_batch(b_inc, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'(0));
      check("midrst_out_valid", 32'(out_valid), 32'(0));
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'(1));
      check("midrst_out_valid2", 32'(out_valid), 32'(0));
      load_batch(b_inc, 1'b0);
      drain_batch(b_inc, 0, 1'b1, 1'b0);

      load_batch(b_rev, 1'b0);
      drain_batch(e_rev, 0, 1'b1, 1'b0);
      load_batch(b_hi, 1'b0);
      drain_batch(b_hi, 0, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
